// File: rtl/smc_fp_pkg.sv
// Shared definitions for the SMC float <-> FP21 sample converters.
// Holds the format widths, the exponent biases and the operand class encoding.
package smc_fp_pkg;

  localparam int SMC_W     = 32;
  localparam int FP_W      = 21;
  localparam int SMC_EW    = 8;
  localparam int FP_EW     = 6;
  localparam int SMC_FW    = 23;
  localparam int FP_FW     = 14;
  localparam int SMC_BIAS  = 127;
  localparam int FP_BIAS   = 31;
  localparam int BIAS_DIFF = 96;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

  // Denormal SMC inputs (exp==0) are treated as zero.
  function automatic cls_e classify(input logic [SMC_EW-1:0] exp,
                                    input logic [SMC_FW-1:0] frac);
    if (exp == '0)
      return CLS_ZERO;
    else if (exp == '1)
      return (frac == '0) ? CLS_INF : CLS_NAN;
    else
      return CLS_NORM;
  endfunction

endpackage

// File: rtl/smc_fp_rounder.sv
// Combinational round-to-nearest-even of a 23-bit SMC fraction down to 14 bits.
// Ports:
//   frac    in  23  SMC fraction (hidden bit not included)
//   frac_r  out 14  rounded FP21 fraction
//   carry   out 1   rounding overflowed the fraction; caller bumps the exponent
module smc_fp_rounder
  import smc_fp_pkg::*;
(
  input  logic [SMC_FW-1:0] frac,
  output logic [FP_FW-1:0]  frac_r,
  output logic              carry
);

  logic [FP_FW-1:0] keep;
  logic             lsb;
  logic             guard;
  logic             sticky;
  logic             round_up;
  logic [FP_FW:0]   sum;

  assign keep     = frac[SMC_FW-1:SMC_FW-FP_FW];
  assign lsb      = frac[SMC_FW-FP_FW];
  assign guard    = frac[SMC_FW-FP_FW-1];
  assign sticky   = |frac[SMC_FW-FP_FW-2:0];
  assign round_up = guard & (sticky | lsb);

  // On carry-out the 14 low bits are all zero, which is exactly the
  // renormalised fraction after the exponent increment.
  assign sum             = {1'b0, keep} + {{FP_FW{1'b0}}, round_up};
  assign {carry, frac_r} = sum;

endmodule

// File: rtl/smc_to_fp_float.sv
// Converts 32-bit SMC floats from the arithmetic datapath into FP21 samples
// for the ADC/host boundary. Three register stages: classify, round, pack.
// One sample per cycle, no backpressure.
// Ports:
//   clk          in  1   clock
//   GlobalReset  in  1   synchronous active-high reset
//   x_i          in  32  SMC float {sign, exp8 bias 127, frac23}
//   srdyi_i      in  1   x_i valid
//   clr_flags_i  in  1   clear ovf_o/unf_o (a same-cycle flag event wins)
//   y_o          out 21  FP21 {sign, exp6 bias 31, frac14}; holds while srdyo_o=0
//   srdyo_o      out 1   y_o valid
//   ovf_o        out 1   sticky: finite input saturated to inf
//   unf_o        out 1   sticky: nonzero input flushed to zero
module smc_to_fp_float
  import smc_fp_pkg::*;
#(
  parameter int               LAT    = 3,
  parameter logic [FP_FW-1:0] NAN_FR = 14'h2000
)(
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic [SMC_W-1:0]  x_i,
  input  logic              srdyi_i,
  input  logic              clr_flags_i,
  output logic [FP_W-1:0]   y_o,
  output logic              srdyo_o,
  output logic              ovf_o,
  output logic              unf_o
);

  if (LAT != 3) begin : g_lat_check
    $error("smc_to_fp_float: LAT must be 3");
  end

  // ---------------- S1: unpack / classify ----------------
  logic                  in_sgn;
  logic [SMC_EW-1:0]     in_exp;
  logic [SMC_FW-1:0]     in_frac;
  logic signed [9:0]     in_e21;

  assign in_sgn  = x_i[SMC_W-1];
  assign in_exp  = x_i[SMC_W-2:SMC_FW];
  assign in_frac = x_i[SMC_FW-1:0];
  assign in_e21  = $signed({2'b00, in_exp}) - 10'sd96;

  logic              v1;
  logic              s1_sgn;
  cls_e              s1_cls;
  logic signed [9:0] s1_exp;
  logic [SMC_FW-1:0] s1_frac;

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      v1      <= 1'b0;
      s1_sgn  <= 1'b0;
      s1_cls  <= CLS_ZERO;
      s1_exp  <= '0;
      s1_frac <= '0;
    end else begin
      v1 <= srdyi_i;
      if (srdyi_i) begin
        s1_sgn  <= in_sgn;
        s1_cls  <= classify(in_exp, in_frac);
        s1_exp  <= in_e21;
        s1_frac <= in_frac;
      end
    end
  end

  // ---------------- S2: round ----------------
  logic [FP_FW-1:0] rnd_frac;
  logic             rnd_carry;

  smc_fp_rounder u_rounder (
    .frac   (s1_frac),
    .frac_r (rnd_frac),
    .carry  (rnd_carry)
  );

  logic              v2;
  logic              s2_sgn;
  cls_e              s2_cls;
  logic signed [9:0] s2_exp;
  logic [FP_FW-1:0]  s2_frac;

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      v2      <= 1'b0;
      s2_sgn  <= 1'b0;
      s2_cls  <= CLS_ZERO;
      s2_exp  <= '0;
      s2_frac <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        s2_sgn  <= s1_sgn;
        s2_cls  <= s1_cls;
        s2_exp  <= s1_exp + $signed({9'b0, rnd_carry});
        s2_frac <= rnd_frac;
      end
    end
  end

  // ---------------- S3: pack / saturate ----------------
  logic [FP_W-1:0] pk_y;
  logic            pk_ovf;
  logic            pk_unf;

  // Range checks use the post-rounding exponent so a carry out of
  // e21=62 saturates.
  always_comb begin
    pk_y   = {s2_sgn, {(FP_W-1){1'b0}}};
    pk_ovf = 1'b0;
    pk_unf = 1'b0;
    unique case (s2_cls)
      CLS_ZERO: pk_y = {s2_sgn, {(FP_W-1){1'b0}}};
      CLS_INF:  pk_y = {s2_sgn, {FP_EW{1'b1}}, {FP_FW{1'b0}}};
      CLS_NAN:  pk_y = {s2_sgn, {FP_EW{1'b1}}, NAN_FR};
      CLS_NORM: begin
        if (s2_exp >= 10'sd63) begin
          pk_y   = {s2_sgn, {FP_EW{1'b1}}, {FP_FW{1'b0}}};
          pk_ovf = 1'b1;
        end else if (s2_exp <= 10'sd0) begin
          pk_y   = {s2_sgn, {(FP_W-1){1'b0}}};
          pk_unf = 1'b1;
        end else begin
          pk_y = {s2_sgn, s2_exp[FP_EW-1:0], s2_frac};
        end
      end
      default: pk_y = {s2_sgn, {(FP_W-1){1'b0}}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      y_o     <= '0;
      srdyo_o <= 1'b0;
      ovf_o   <= 1'b0;
      unf_o   <= 1'b0;
    end else begin
      srdyo_o <= v2;
      if (v2)
        y_o <= pk_y;
      // A flag event in the clearing cycle must not be lost.
      ovf_o <= (ovf_o & ~clr_flags_i) | (v2 & pk_ovf);
      unf_o <= (unf_o & ~clr_flags_i) | (v2 & pk_unf);
    end
  end

endmodule
